pacman_sfx_player: RTL

PACMAN_SFX_PLAYER -- requirements
Module: pacman_sfx_player

---
 rtl/pacman_sfx_pkg.sv | 14 +
 rtl/pacman_tone_gen.sv | 78 +++++++
 rtl/pacman_sfx_player.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pacman_sfx_pkg.sv
// Shared types and widths for the Pac-Man sound-effect player.
package pacman_sfx_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 9;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StLoad,
        StPlay
    } sfx_state_e;

endpackage

// File: rtl/pacman_tone_gen.sv
// Square-wave tone generator: a PRESCALE-clk prescaler drives a half-period down-counter
// whose expiry toggles the tone and reloads the captured half period.
module pacman_tone_gen
    import pacman_sfx_pkg::*;
#(
    parameter int unsigned PRESCALE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] half_period,
    output logic              tone
);

    localparam int unsigned PRE_W = 8;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] half_period_q, half_period_d;
    logic              tone_q, tone_d;
    logic              step;

    always_comb begin
        pre_d         = pre_q;
        cnt_d         = cnt_q;
        half_period_d = half_period_q;
        tone_d        = tone_q;
        step          = 1'b0;
        if (clear) begin
            pre_d  = '0;
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (load) begin
            pre_d         = '0;
            cnt_d         = half_period;
            half_period_d = half_period;
            // A zero half period is silence, regardless of the phase left by the last entry.
            if (half_period == '0) begin
                tone_d = 1'b0;
            end
        end else if (enable) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                step  = 1'b1;
            end else begin
                pre_d = pre_q + 8'd1;
            end
            if (step && (half_period_q != '0)) begin
                if (cnt_q <= 9'd1) begin
                    tone_d = ~tone_q;
                    cnt_d  = half_period_q;
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q         <= '0;
            cnt_q         <= '0;
            half_period_q <= '0;
            tone_q        <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            cnt_q         <= cnt_d;
            half_period_q <= half_period_d;
            tone_q        <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/pacman_sfx_player.sv
// Plays a tone table from an external registered ROM, one entry per ENTRY_CYCLES clks.
// Define SFX_RETRIGGER_EN to let start restart playback while busy.
module pacman_sfx_player
    import pacman_sfx_pkg::*;
#(
    parameter int unsigned       PRESCALE     = 16,
    parameter int unsigned       ENTRY_CYCLES = 4096,
    parameter logic [DATA_W-1:0] END_CODE     = 9'd511
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              audio_out,
    output logic              busy,
    output logic              done
);

    localparam logic [15:0] TIMER_LAST = 16'(ENTRY_CYCLES - 1);

    sfx_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       timer_q, timer_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tone_en, tone_load, tone_clear;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        timer_d    = timer_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tone_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = '0;
                    timer_d = '0;
                    busy_d  = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                timer_d = '0;
                if (rom_data == END_CODE) begin
                    state_d    = StIdle;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    tone_clear = 1'b1;
                end else begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    // The last table slot ends playback instead of wrapping to entry 0.
                    if (addr_q == '1) begin
                        state_d    = StIdle;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        tone_clear = 1'b1;
                    end else begin
                        addr_d  = addr_q + 10'd1;
                        state_d = StFetch;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef SFX_RETRIGGER_EN
        if (start && (state_q != StIdle)) begin
            state_d    = StFetch;
            addr_d     = '0;
            timer_d    = '0;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            tone_clear = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            timer_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            timer_q <= timer_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tone_en   = (state_q == StPlay);
    assign tone_load = (state_q == StLoad) && (rom_data != END_CODE);

    pacman_tone_gen #(
        .PRESCALE(PRESCALE)
    ) u_tone (
        .clk        (clk),
        .rst        (rst),
        .enable     (tone_en),
        .load       (tone_load),
        .clear      (tone_clear),
        .half_period(rom_data),
        .tone       (audio_out)
    );

    assign rom_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
